puf_response_voter: RTL and testbench

- Control stage directly upstream and downstream of the ring-oscillator PUF core.
- Accepts an 8-bit challenge request and drives the PUF NUM_READS times with the same challenge.
- Collects each 8-bit response on the core's ready pulse and majority-votes every bit.
- Presents one stabilised response byte plus an instability flag to the consumer (key register or host) over a valid/ack handshake.

---
 rtl/puf_response_voter.sv | 176 +++++++++++++++++
 tb/tb_puf_response_voter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_voter.sv
// puf_response_voter
//   Runs NUM_READS evaluations of the ring-oscillator PUF with one latched
//   challenge, majority-votes each response bit and hands the voted byte to
//   the consumer over a valid/ack handshake.
// Ports:
//   clk, rst            clock, async active-low reset
//   start, chall_in     request strobe and challenge (taken only in IDLE)
//   puf_chall, puf_en   challenge and oscillator enable to the PUF core
//   puf_response        PUF response bus, sampled on the rising edge of puf_ready
//   puf_ready           PUF ready level
//   key_out, unstable   voted byte and "some bit was not unanimous" flag
//   key_valid, key_ack  consumer handshake
//   busy                high outside IDLE
//   err                 timeout seen; sticky until the next accepted start

// One vote counter per response bit. Majority and split flags are derived
// from the next count so the top can register them on the final read.
module puf_vote_lane #(
  parameter int NUM_READS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_bit,
  output logic o_maj,
  output logic o_split
);
  logic [3:0] r_vote;
  logic [3:0] w_vote_nxt;

  always_comb begin
    w_vote_nxt = r_vote;
    if (i_clr)               w_vote_nxt = '0;
    else if (i_inc && i_bit) w_vote_nxt = r_vote + 4'd1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_vote <= '0;
    else      r_vote <= w_vote_nxt;

  assign o_maj   = (w_vote_nxt > 4'(NUM_READS / 2));
  assign o_split = (w_vote_nxt != 4'd0) && (w_vote_nxt != 4'(NUM_READS));
endmodule

module puf_response_voter #(
  parameter int NUM_READS  = 5,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] chall_in,
  output logic [7:0] puf_chall,
  output logic       puf_en,
  input  logic [7:0] puf_response,
  input  logic       puf_ready,
  output logic [7:0] key_out,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       unstable,
  output logic       busy,
  output logic       err
);
  localparam logic [3:0]  LP_NREADS  = 4'(NUM_READS);
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  localparam logic [3:0]  LP_GAP_END = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t      r_state, w_next;
  logic        r_rdy_q;
  logic [3:0]  r_read_cnt;
  logic [15:0] r_timer;
  logic [3:0]  r_gap;
  logic [7:0]  r_chall;
  logic [7:0]  r_key;
  logic        r_unst;
  logic        r_kvalid;
  logic        r_err;

  logic        w_rdy_edge, w_clr, w_inc, w_last;
  logic [7:0]  w_maj, w_split;

  // A ready level already high on entry to WAIT is stale: only an edge counts.
  assign w_rdy_edge = puf_ready & ~r_rdy_q;
  assign w_clr      = (r_state == S_IDLE) & start;
  assign w_inc      = (r_state == S_WAIT) & w_rdy_edge;
  assign w_last     = w_inc & ((r_read_cnt + 4'd1) == LP_NREADS);

  for (genvar g = 0; g < 8; g++) begin : g_lane
    puf_vote_lane #(.NUM_READS(NUM_READS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_inc   (w_inc),
      .i_bit   (puf_response[g]),
      .o_maj   (w_maj[g]),
      .o_split (w_split[g])
    );
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;

  // Ready edge takes priority over the timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_rdy_edge)                w_next = w_last ? S_DONE : S_GAP;
        else if (r_timer == LP_TIMEOUT) w_next = S_ERR;
      end
      S_GAP:    if (r_gap == LP_GAP_END) w_next = S_LAUNCH;
      S_DONE:   if (key_ack) w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_q    <= 1'b0;
      r_read_cnt <= '0;
      r_timer    <= '0;
      r_gap      <= '0;
      r_chall    <= '0;
      r_key      <= '0;
      r_unst     <= 1'b0;
      r_kvalid   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rdy_q <= puf_ready;
      case (r_state)
        S_IDLE: if (start) begin
          r_chall    <= chall_in;
          r_read_cnt <= '0;
          r_err      <= 1'b0;
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (w_rdy_edge) begin
            r_read_cnt <= r_read_cnt + 4'd1;
            r_gap      <= '0;
            if (w_last) begin
              r_key    <= w_maj;
              r_unst   <= |w_split;
              r_kvalid <= 1'b1;
            end
          end else if (r_timer == LP_TIMEOUT) begin
            r_err <= 1'b1;
          end
        end
        S_GAP:  r_gap <= r_gap + 4'd1;
        S_DONE: if (key_ack) r_kvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Combinational from state so reset drops the enable immediately.
  assign puf_en    = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign busy      = (r_state != S_IDLE);
  assign puf_chall = r_chall;
  assign key_out   = r_key;
  assign unstable  = r_unst;
  assign key_valid = r_kvalid;
  assign err       = r_err;
endmodule

// File: tb/tb_puf_response_voter.sv
module tb_puf_response_voter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] chall_in = '0;
  logic [7:0] puf_chall;
  logic       puf_en;
  logic [7:0] puf_response;
  logic       puf_ready;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       unstable;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  puf_response_voter #(.NUM_READS(5), .TIMEOUT(16), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .chall_in(chall_in),
    .puf_chall(puf_chall), .puf_en(puf_en), .puf_response(puf_response),
    .puf_ready(puf_ready), .key_out(key_out), .key_valid(key_valid),
    .key_ack(key_ack), .unstable(unstable), .busy(busy), .err(err)
  );

  // PUF core model. mode 0: raise ready mdl_delay enable-cycles after launch
  // with the next queued response; 1: never ready; 2: bench drives directly.
  int         mdl_mode = 0;
  int         mdl_delay = 3;
  logic [7:0] mdl_resp [0:4];
  int         mdl_idx = 0;
  int         mdl_cnt = 0;
  logic       mdl_ready = 1'b0;
  logic [7:0] mdl_resp_q = '0;
  logic       man_ready = 1'b0;
  logic [7:0] man_resp = '0;

  assign puf_ready    = (mdl_mode == 2) ? man_ready : mdl_ready;
  assign puf_response = (mdl_mode == 2) ? man_resp  : mdl_resp_q;

  always @(negedge clk) begin
    if (!busy) mdl_idx <= 0;
    if (!puf_en) begin
      mdl_ready <= 1'b0;
      mdl_cnt   <= 0;
    end else begin
      mdl_cnt <= mdl_cnt + 1;
      if (mdl_cnt + 1 == mdl_delay && mdl_mode == 0 && mdl_idx < 5) begin
        mdl_ready  <= 1'b1;
        mdl_resp_q <= mdl_resp[mdl_idx];
        mdl_idx    <= mdl_idx + 1;
      end
    end
  end

  // Enable pulse counter and challenge watcher.
  logic [7:0] exp_chall = '0;
  logic       en_q = 1'b0;
  int         n_pulses = 0;
  int         n_badch = 0;
  always @(negedge clk) begin
    en_q <= puf_en;
    if (puf_en && !en_q) n_pulses <= n_pulses + 1;
    if (puf_en && (puf_chall !== exp_chall)) n_badch <= n_badch + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]      chall;
    logic [4:0][7:0] resp;     // leftmost listed = first read
    logic [3:0]      dly;
    logic [7:0]      exp_key;
    logic            exp_unst;
  } vec_t;

  typedef struct packed {
    logic [7:0] key;
    logic       unst;
  } exp_t;

  exp_t exp_q[$];

  task automatic wait_kv(input string nm);
    int n = 0;
    while (!key_valid && n < 500) begin @(negedge clk); n++; end
    chk(nm, {15'd0, key_valid}, 16'd1);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_key"},  {8'd0, key_out},       {8'd0, e.key});
    chk({nm, "_unst"}, {15'd0, unstable},     {15'd0, e.unst});
  endtask

  task automatic ack_and_check(input string nm, input logic [7:0] key_exp);
    @(negedge clk) key_ack = 1'b1;
    @(negedge clk) key_ack = 1'b0;
    chk({nm, "_kv_after_ack"},   {15'd0, key_valid}, 16'd0);
    chk({nm, "_busy_after_ack"}, {15'd0, busy},      16'd0);
    chk({nm, "_key_retained"},   {8'd0, key_out},    {8'd0, key_exp});
  endtask

  task automatic run_req(input vec_t v, input int ack_wait, input bit poke);
    int p0, b0;
    bit stable;
    for (int i = 0; i < 5; i++) mdl_resp[i] = v.resp[4 - i];
    mdl_delay = int'(v.dly);
    mdl_mode  = 0;
    exp_chall = v.chall;
    exp_q.push_back('{v.exp_key, v.exp_unst});
    p0 = n_pulses;
    b0 = n_badch;
    @(negedge clk) begin start = 1'b1; chall_in = v.chall; end
    @(negedge clk) begin start = 1'b0; chall_in = 8'h00; end
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    chk("err_cleared",      {15'd0, err},  16'd0);
    if (poke) begin
      @(negedge clk) begin start = 1'b1; chall_in = 8'hFF; end
      @(negedge clk) begin start = 1'b0; chall_in = 8'h00; end
    end
    wait_kv("key_valid_seen");
    pop_cmp("vote");
    chk("pulses",   16'(n_pulses - p0), 16'd5);
    chk("chall_ok", 16'(n_badch - b0),  16'd0);
    if (ack_wait > 0) begin
      stable = 1'b1;
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clk);
        if (!key_valid || key_out !== v.exp_key || unstable !== v.exp_unst) stable = 1'b0;
      end
      chk("hold_stable", {15'd0, stable}, 16'd1);
    end
    ack_and_check("req", v.exp_key);
  endtask

  vec_t tv [0:5];

  initial begin
    tv[0] = '{8'h5A, {8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3}, 4'd3, 8'hC3, 1'b0};
    tv[1] = '{8'h21, {8'hF0, 8'hF1, 8'hF0, 8'h70, 8'hF0}, 4'd4, 8'hF0, 1'b1};
    tv[2] = '{8'h3C, {8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA}, 4'd2, 8'hAA, 1'b1};
    tv[3] = '{8'h7E, {8'h01, 8'h02, 8'h04, 8'h08, 8'h10}, 4'd5, 8'h00, 1'b1};
    tv[4] = '{8'h99, {8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF}, 4'd6, 8'hFF, 1'b1};
    tv[5] = '{8'h00, {8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F}, 4'd2, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) mdl_resp[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_puf_en",    {15'd0, puf_en},    16'd0);
    chk("rst_busy",      {15'd0, busy},      16'd0);
    chk("rst_key_valid", {15'd0, key_valid}, 16'd0);
    chk("rst_err",       {15'd0, err},       16'd0);
    chk("rst_unstable",  {15'd0, unstable},  16'd0);
    chk("rst_key_out",   {8'd0, key_out},    16'd0);
    chk("rst_puf_chall", {8'd0, puf_chall},  16'd0);
    rst = 1'b1;

    // key_ack in IDLE is ignored
    @(negedge clk) key_ack = 1'b1;
    @(negedge clk) key_ack = 1'b0;
    chk("ack_idle_busy", {15'd0, busy},      16'd0);
    chk("ack_idle_kv",   {15'd0, key_valid}, 16'd0);

    // Table: first entry also pokes start mid-request and holds ack off 10 cycles
    for (int i = 0; i < 6; i++)
      run_req(tv[i], (i == 0) ? 10 : (i % 3), i == 0);

    // Stale ready: high on entry to WAIT must not count
    begin
      int n;
      bit en_held;
      mdl_mode  = 2;
      man_ready = 1'b1;
      man_resp  = 8'hEE;
      exp_chall = 8'h3C;
      exp_q.push_back('{8'h11, 1'b0});
      @(negedge clk) begin start = 1'b1; chall_in = 8'h3C; end
      @(negedge clk) begin start = 1'b0; chall_in = 8'h00; end
      en_held = 1'b1;
      repeat (4) begin @(negedge clk); if (!puf_en) en_held = 1'b0; end
      chk("stale_no_count", {15'd0, en_held}, 16'd1);
      man_ready = 1'b0;
      repeat (2) @(negedge clk);
      man_resp  = 8'h11;
      man_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
        if (r > 0) begin
          n = 0;
          while (!puf_en && n < 20) begin @(negedge clk); n++; end
          repeat (2) @(negedge clk);
          man_ready = 1'b1;
        end
        n = 0;
        while (puf_en && n < 20) begin @(negedge clk); n++; end
        man_ready = 1'b0;
      end
      chk("stale_en_low", {15'd0, puf_en}, 16'd0);
      wait_kv("stale_kv");
      pop_cmp("stale");
      ack_and_check("stale", 8'h11);
      mdl_mode = 0;
    end

    // Timeout: ready never rises
    begin
      int en_cycles = 0;
      int n = 0;
      mdl_mode  = 1;
      exp_chall = 8'h42;
      @(negedge clk) begin start = 1'b1; chall_in = 8'h42; end
      @(negedge clk) begin start = 1'b0; chall_in = 8'h00; end
      while (!err && n < 100) begin
        if (puf_en) en_cycles++;
        @(negedge clk);
        n++;
      end
      chk("to_err",       {15'd0, err},       16'd1);
      chk("to_en_cycles", 16'(en_cycles),     16'd18);
      chk("to_kv",        {15'd0, key_valid}, 16'd0);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", {15'd0, err},  16'd1);
      chk("to_idle",       {15'd0, busy}, 16'd0);
      run_req(tv[1], 0, 1'b0);
    end

    // Reset mid-run after two reads, then a fresh request
    begin
      int n = 0;
      for (int i = 0; i < 5; i++) mdl_resp[i] = 8'hFF;
      mdl_mode  = 0;
      mdl_delay = 3;
      exp_chall = 8'h77;
      @(negedge clk) begin start = 1'b1; chall_in = 8'h77; end
      @(negedge clk) begin start = 1'b0; chall_in = 8'h00; end
      while (mdl_idx < 2 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (!puf_en && n < 20) begin @(negedge clk); n++; end
      chk("mr_running", {15'd0, puf_en}, 16'd1);
      rst = 1'b0;
      #1;
      chk("mr_puf_en", {15'd0, puf_en},    16'd0);
      chk("mr_busy",   {15'd0, busy},      16'd0);
      chk("mr_kv",     {15'd0, key_valid}, 16'd0);
      @(negedge clk) rst = 1'b1;
      run_req(tv[5], 2, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
